// File: rtl/imem_boot_loader.sv
// Boot loader: accepts a program over a valid/ready stream, writes it into
// instruction memory, then enables the core for a bounded or halt-ended run.
module imem_boot_loader #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 7,
    parameter int DEPTH      = 128,
    parameter int RUN_CYCLES = 357,
    parameter int AUTO_RUN   = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load_req,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [DATA_W-1:0]   s_data,
    input  logic                s_last,
    input  logic                start,
    input  logic                halt,
    output logic                inst_wen,
    output logic [ADDR_W-1:0]   inst_addr,
    output logic [DATA_W-1:0]   inst_data,
    output logic                enb,
    output logic                done,
    output logic                err,
    output logic [ADDR_W:0]     word_cnt,
    output logic [31:0]         cycle_cnt
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WAIT_START,
        RUN,
        DONE,
        ERR
    } state_t;

    localparam logic [ADDR_W:0] LAST_IDX  = (ADDR_W+1)'(DEPTH - 1);
    localparam logic [ADDR_W:0] WORD_ONE  = (ADDR_W+1)'(1);
    localparam logic [31:0]     RUN_LIMIT = 32'(RUN_CYCLES);
    localparam logic [31:0]     CNT_MAX   = '1;

    state_t state;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == CNT_MAX) ? v : v + 32'd1;
    endfunction

    // Ready depends on state only, so the upstream source never sees a loop.
    assign s_ready = (state == LOAD);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            inst_wen  <= 1'b0;
            inst_addr <= '0;
            inst_data <= '0;
            enb       <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            word_cnt  <= '0;
            cycle_cnt <= '0;
        end else begin
            inst_wen <= 1'b0;
            case (state)
                IDLE, DONE, ERR: begin
                    if (load_req) begin
                        word_cnt  <= '0;
                        cycle_cnt <= '0;
                        done      <= 1'b0;
                        err       <= 1'b0;
                        state     <= LOAD;
                    end
                end
                LOAD: begin
                    if (s_valid) begin
                        inst_wen  <= 1'b1;
                        inst_addr <= word_cnt[ADDR_W-1:0];
                        inst_data <= s_data;
                        word_cnt  <= word_cnt + WORD_ONE;
                        if (s_last) begin
                            if (AUTO_RUN != 0) begin
                                enb   <= 1'b1;
                                state <= RUN;
                            end else begin
                                state <= WAIT_START;
                            end
                        end else if (word_cnt == LAST_IDX) begin
                            err   <= 1'b1;
                            state <= ERR;
                        end
                    end
                end
                WAIT_START: begin
                    if (start) begin
                        enb   <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    // A reload aborts the run outright; the aborted run never reports done.
                    if (load_req) begin
                        enb       <= 1'b0;
                        word_cnt  <= '0;
                        cycle_cnt <= '0;
                        state     <= LOAD;
                    end else begin
                        cycle_cnt <= sat_inc(cycle_cnt);
                        if (halt || (RUN_CYCLES > 0 && sat_inc(cycle_cnt) == RUN_LIMIT)) begin
                            enb   <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Scoreboard bench for imem_boot_loader: a default instance and a small
// DEPTH=8 / manual-start / unbounded-run instance share the stream inputs.
module tb_imem_boot_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_load_req, b_load_req;
    logic        s_valid, s_last, start, halt;
    logic [31:0] s_data;

    logic        a_s_ready, a_inst_wen, a_enb, a_done, a_err;
    logic [6:0]  a_inst_addr;
    logic [31:0] a_inst_data, a_cycle_cnt;
    logic [7:0]  a_word_cnt;
    logic        b_s_ready, b_inst_wen, b_enb, b_done, b_err;
    logic [6:0]  b_inst_addr;
    logic [31:0] b_inst_data, b_cycle_cnt;
    logic [7:0]  b_word_cnt;

    int n_pass = 0;
    int n_total = 0;
    logic [38:0] q_a[$];
    logic [38:0] q_b[$];
    logic [38:0] e_a, e_b;
    logic [6:0]  exp_addr_a, exp_addr_b;
    bit          sel_b;
    int          a_writes = 0;
    int          b_enb_cycles = 0;

    imem_boot_loader u_a (
        .clk(clk), .rst(rst), .load_req(a_load_req), .s_valid(s_valid), .s_ready(a_s_ready),
        .s_data(s_data), .s_last(s_last), .start(start), .halt(halt), .inst_wen(a_inst_wen),
        .inst_addr(a_inst_addr), .inst_data(a_inst_data), .enb(a_enb), .done(a_done),
        .err(a_err), .word_cnt(a_word_cnt), .cycle_cnt(a_cycle_cnt)
    );

    imem_boot_loader #(.DEPTH(8), .RUN_CYCLES(0), .AUTO_RUN(0)) u_b (
        .clk(clk), .rst(rst), .load_req(b_load_req), .s_valid(s_valid), .s_ready(b_s_ready),
        .s_data(s_data), .s_last(s_last), .start(start), .halt(halt), .inst_wen(b_inst_wen),
        .inst_addr(b_inst_addr), .inst_data(b_inst_data), .enb(b_enb), .done(b_done),
        .err(b_err), .word_cnt(b_word_cnt), .cycle_cnt(b_cycle_cnt)
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endfunction

    always @(negedge clk) begin
        if (a_inst_wen) begin
            a_writes++;
            if (q_a.size() == 0) check("a_unexpected_write", 1, 0);
            else begin
                e_a = q_a.pop_front();
                check("a_write", {25'b0, a_inst_addr, a_inst_data}, {25'b0, e_a});
            end
        end
    end

    always @(negedge clk) begin
        if (b_enb) b_enb_cycles++;
        if (b_inst_wen) begin
            if (q_b.size() == 0) check("b_unexpected_write", 1, 0);
            else begin
                e_b = q_b.pop_front();
                check("b_write", {25'b0, b_inst_addr, b_inst_data}, {25'b0, e_b});
            end
        end
    end

    function automatic bit cur_ready();
        return sel_b ? b_s_ready : a_s_ready;
    endfunction

    task automatic pulse_load(input bit b);
        @(negedge clk);
        sel_b = b;
        if (b) begin b_load_req = 1'b1; exp_addr_b = '0; end
        else begin a_load_req = 1'b1; exp_addr_a = '0; end
        @(posedge clk); #1;
        a_load_req = 1'b0;
        b_load_req = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] d, input logic last);
        int guard;
        guard = 0;
        @(negedge clk);
        s_valid = 1'b1; s_data = d; s_last = last;
        while (!cur_ready() && guard < 20) begin @(negedge clk); guard++; end
        if (guard >= 20) check("send_timeout", 1, 0);
        else if (sel_b) begin q_b.push_back({exp_addr_b, d}); exp_addr_b++; end
        else begin q_a.push_back({exp_addr_a, d}); exp_addr_a++; end
        @(posedge clk); #1;
        s_valid = 1'b0; s_last = 1'b0;
    endtask

    task automatic count_a_enb(output int n);
        int guard;
        bit e;
        n = 0; guard = 0; e = 1'b1;
        while (e && guard < 5000) begin
            @(negedge clk);
            e = a_enb;
            if (e) n++;
            guard++;
        end
        if (guard >= 5000) check("a_run_timeout", 1, 0);
    endtask

    task automatic check_a_zero(input string tag);
        check({tag, "_s_ready"}, a_s_ready, 0);
        check({tag, "_inst_wen"}, a_inst_wen, 0);
        check({tag, "_inst_addr"}, a_inst_addr, 0);
        check({tag, "_inst_data"}, a_inst_data, 0);
        check({tag, "_enb"}, a_enb, 0);
        check({tag, "_done"}, a_done, 0);
        check({tag, "_err"}, a_err, 0);
        check({tag, "_word_cnt"}, a_word_cnt, 0);
        check({tag, "_cycle_cnt"}, a_cycle_cnt, 0);
    endtask

    initial begin
        int n;
        int guard;
        int w0;
        rst = 1'b1; a_load_req = 0; b_load_req = 0; s_valid = 0; s_last = 0;
        start = 0; halt = 0; s_data = '0; sel_b = 0; exp_addr_a = '0; exp_addr_b = '0;
        repeat (2) @(negedge clk);
        check_a_zero("rst_a");
        check("rst_b_all", {b_s_ready, b_inst_wen, b_inst_addr, b_inst_data, b_enb, b_done, b_err},
              0);
        check("rst_b_cnts", {b_word_cnt, b_cycle_cnt}, 0);
        @(negedge clk); rst = 1'b0;

        // Overflow on the 8-deep instance
        pulse_load(1);
        for (int i = 0; i < 8; i++) send_word(32'h1000_0000 + i, 1'b0);
        check("ovf_err", b_err, 1);
        check("ovf_s_ready", b_s_ready, 0);
        check("ovf_word_cnt", b_word_cnt, 8);
        s_valid = 1'b1; s_data = 32'hdead_beef;
        repeat (20) @(negedge clk);
        s_valid = 1'b0;
        check("ovf_enb_never", b_enb_cycles, 0);
        check("ovf_q_empty", q_b.size(), 0);
        check("ovf_err_hold", b_err, 1);

        // Manual start, run until halt
        pulse_load(1);
        check("ws_err_cleared", b_err, 0);
        check("ws_word_cnt_cleared", b_word_cnt, 0);
        send_word(32'h0000_0013, 1'b0);
        send_word(32'h0010_0073, 1'b1);
        @(negedge clk); b_load_req = 1'b1;
        @(posedge clk); #1; b_load_req = 1'b0;
        check("ws_reload_ignored", b_word_cnt, 2);
        check("ws_s_ready", b_s_ready, 0);
        repeat (10) @(negedge clk);
        check("ws_enb_low", b_enb_cycles, 0);
        check("ws_done_low", b_done, 0);
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        check("ws_enb_on_start", b_enb, 1);
        n = 0; guard = 0;
        while (n < 50 && guard < 200) begin
            @(negedge clk);
            if (b_enb) n++;
            guard++;
        end
        halt = 1'b1;
        @(posedge clk); #1; halt = 1'b0;
        check("halt_enb", b_enb, 0);
        check("halt_done", b_done, 1);
        check("halt_cycle_cnt", b_cycle_cnt, 50);
        check("halt_enb_cycles", b_enb_cycles, 50);
        repeat (5) @(negedge clk);
        check("halt_done_hold", b_done, 1);
        check("halt_cnt_hold", b_cycle_cnt, 50);

        // Four-word program, bounded auto run
        pulse_load(0);
        check("ld_s_ready", a_s_ready, 1);
        check("ld_word_cnt0", a_word_cnt, 0);
        send_word(32'h0050_0093, 1'b0);
        send_word(32'h00a0_0113, 1'b0);
        send_word(32'h0020_81b3, 1'b0);
        send_word(32'h0000_0073, 1'b1);
        check("run_enb_first", a_enb, 1);
        check("run_word_cnt", a_word_cnt, 4);
        count_a_enb(n);
        check("run_enb_cycles", n, 357);
        check("run_done", a_done, 1);
        check("run_cycle_cnt", a_cycle_cnt, 357);
        check("run_word_cnt_hold", a_word_cnt, 4);

        // Gapped stream, then abort at run cycle 20
        pulse_load(0);
        check("gap_done_cleared", a_done, 0);
        check("gap_cnt_cleared", a_cycle_cnt, 0);
        send_word(32'h1111_1111, 1'b0);
        @(posedge clk); #1;
        send_word(32'h2222_2222, 1'b0);
        @(posedge clk); #1;
        send_word(32'h3333_3333, 1'b1);
        check("gap_word_cnt", a_word_cnt, 3);
        n = 0; guard = 0;
        while (n < 20 && guard < 100) begin
            @(negedge clk);
            if (a_enb) n++;
            guard++;
        end
        a_load_req = 1'b1;
        @(posedge clk); #1; a_load_req = 1'b0;
        exp_addr_a = '0;
        check("abort_enb", a_enb, 0);
        check("abort_done", a_done, 0);
        check("abort_cycle_cnt", a_cycle_cnt, 0);
        check("abort_word_cnt", a_word_cnt, 0);
        check("abort_s_ready", a_s_ready, 1);
        send_word(32'h0bad_c0de, 1'b1);
        count_a_enb(n);
        check("rerun_enb_cycles", n, 357);
        check("rerun_done", a_done, 1);
        check("rerun_word_cnt", a_word_cnt, 1);

        // Asynchronous reset during word 3
        pulse_load(0);
        send_word(32'ha000_0000, 1'b0);
        send_word(32'ha000_0001, 1'b0);
        send_word(32'ha000_0002, 1'b0);
        @(negedge clk);
        s_valid = 1'b1; s_data = 32'ha000_0003;
        #2 rst = 1'b1;
        #1;
        check_a_zero("async_rst");
        check("async_rst_q_empty", q_a.size(), 0);
        @(negedge clk); rst = 1'b0;
        w0 = a_writes;
        repeat (10) @(negedge clk);
        s_valid = 1'b0;
        check("post_rst_no_write", a_writes, w0);
        check("post_rst_s_ready", a_s_ready, 0);
        check("post_rst_word_cnt", a_word_cnt, 0);

        check("final_q_a_empty", q_a.size(), 0);
        check("final_q_b_empty", q_b.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/imem_boot_loader.md
IMEM_BOOT_LOADER -- requirements
Module: imem_boot_loader

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32: instruction word width.
REQ-002 The block SHALL have parameter ADDR_W, default 7: instruction memory address width.
REQ-003 The block SHALL have parameter DEPTH, default 128: maximum loadable words, at most 2^ADDR_W.
REQ-004 The block SHALL have parameter RUN_CYCLES, default 357: core-enable cycles per run; 0 means run until halt.
REQ-005 The block SHALL have parameter AUTO_RUN, default 1: 1 starts the run after load, 0 waits for start.
REQ-006 The block SHALL have port clk, input, 1: the single clock, all logic on its rising edge.
REQ-007 The block SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-008 The block SHALL have port load_req, input, 1: one-cycle pulse that begins a program load.
REQ-009 The block SHALL have port s_valid, input, 1: stream word valid.
REQ-010 The block SHALL have port s_ready, output, 1: stream word accepted when high together with s_valid.
REQ-011 The block SHALL have port s_data, input, DATA_W: stream instruction word.
REQ-012 The block SHALL have port s_last, input, 1: marks the final program word.
REQ-013 The block SHALL have port start, input, 1: run start pulse, used only when AUTO_RUN=0.
REQ-014 The block SHALL have port halt, input, 1: ends the run early.
REQ-015 The block SHALL have port inst_wen, output, 1: instruction memory write enable.
REQ-016 The block SHALL have port inst_addr, output, ADDR_W: instruction memory write address.
REQ-017 The block SHALL have port inst_data, output, DATA_W: instruction memory write data.
REQ-018 The block SHALL have port enb, output, 1: core enable.
REQ-019 The block SHALL have port done, output, 1: run complete, held until the next load.
REQ-020 The block SHALL have port err, output, 1: overflow, meaning DEPTH words were received without s_last.
REQ-021 The block SHALL have port word_cnt, output, ADDR_W+1: count of words written in the current load.
REQ-022 The block SHALL have port cycle_cnt, output, 32: count of enb-high cycles in the current run.

Function
REQ-023 The FSM SHALL have the states IDLE, LOAD, WAIT_START, RUN, DONE and ERR.
REQ-024 In IDLE, DONE or ERR, load_req SHALL clear word_cnt, cycle_cnt, done and err and enter LOAD on the next cycle.
REQ-025 s_ready SHALL be high only in LOAD; it SHALL be combinational from the state only, never from s_valid.
REQ-026 On a handshake, the block SHALL register inst_wen=1, inst_addr=word_cnt[ADDR_W-1:0] and inst_data=s_data, so the write appears one cycle after the handshake.
REQ-027 Each handshake SHALL increment word_cnt by 1.
REQ-028 inst_wen SHALL be a single-cycle pulse per accepted word, and SHALL be low at all other times.
REQ-029 A handshake with s_last=1 SHALL write that word, then enter RUN when AUTO_RUN=1, else WAIT_START.
REQ-030 The handshake of word index DEPTH-1 with s_last=0 SHALL write that word, then enter ERR; in ERR, err=1 and enb stays 0.
REQ-031 In WAIT_START, a start pulse SHALL enter RUN; start in any other state SHALL be ignored.
REQ-032 In RUN, enb SHALL be 1 (registered, first high the cycle RUN is entered) and cycle_cnt SHALL increment each cycle, saturating at 2^32-1.
REQ-033 With RUN_CYCLES>0, the block SHALL leave RUN after exactly RUN_CYCLES enb-high cycles, then enter DONE.
REQ-034 halt=1 in RUN SHALL enter DONE on the next cycle, and halt SHALL take priority over RUN_CYCLES expiry in the same cycle.
REQ-035 load_req in RUN SHALL abort the run: enb low the next cycle, done stays 0, counters clear, state enters LOAD.
REQ-036 load_req in LOAD or WAIT_START SHALL be ignored.
REQ-037 In DONE, done SHALL be 1 and enb 0; cycle_cnt and word_cnt SHALL hold.
REQ-038 An empty program SHALL be impossible; the first accepted word with s_last=1 SHALL yield a 1-word load.

Reset
REQ-039 rst=1 SHALL immediately force IDLE and set s_ready, inst_wen, inst_addr, inst_data, enb, done, err, word_cnt and cycle_cnt to 0, regardless of clk.
REQ-040 Reset mid-load or mid-run SHALL drop inst_wen and enb asynchronously.
REQ-041 After reset, no memory write SHALL occur until a new load_req.

Verification
REQ-042 The bench SHALL cover: defaults, load_req, then 4 words 0x00500093, 0x00a00113, 0x002081b3, 0x00000073 (the last with s_last) -> inst_wen pulses at addr 0..3 with matching data, word_cnt=4, enb high 357 cycles, then done=1 and cycle_cnt=357.
REQ-043 The bench SHALL cover: s_valid toggled every other cycle during load -> writes only on handshake cycles, with addresses contiguous and no gaps.
REQ-044 The bench SHALL cover: DEPTH=8 with 8 words and no s_last -> 8 writes at addr 0..7, err=1, enb never high, s_ready=0 afterwards.
REQ-045 The bench SHALL cover: AUTO_RUN=0 and RUN_CYCLES=0, 2-word load -> remains in WAIT_START with enb=0; start -> enb=1; halt after 50 cycles -> done=1 with cycle_cnt=50.
REQ-046 The bench SHALL cover: load_req at run cycle 20 -> enb=0 next cycle, done=0, cycle_cnt=0, s_ready=1; a new 1-word load then runs normally.
REQ-047 The bench SHALL cover: rst asserted between clock edges during load word 3 -> all outputs 0 before the next edge, and no write after rst deasserts until load_req.
